rf_access_ctrl: RTL and testbench

- Controller and round-robin arbiter that shares one 8-entry x 8-bit single-port flip-flop register file between two requesters (A and B).
- Only one read or one write reaches the register file per cycle. The register file can therefore never see the illegal simultaneous rd+wr condition.
- A built-in clear sequencer zeroes all entries on request.
- Sits between the requesters and the register file's din/addr/wr/rd/dout/error ports.

---
 rtl/rf_access_ctrl.sv | 78 +++++++
 tb/tb_rf_access_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: round-robin two-requester front end with clear sequencer for a single-port register file.
module rf_access_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic [DW-1:0] rf_din,
  output logic [AW-1:0] rf_addr,
  output logic          rf_wr,
  output logic          rf_rd,
  input  logic [DW-1:0] rf_dout,
  input  logic          rf_error,
  output logic          err_sticky
);
  typedef enum logic {NORMAL, CLEAR} state_t;
  state_t state;
  logic last_b, tag_v, tag_b, any_gnt, g_we;
  logic [AW-1:0] cnt;
  assign clr_busy = state == CLEAR;
  // last_b set means B was granted last, so A wins the next contention
  assign a_gnt = !clr_busy && a_req && (!b_req || last_b);
  assign b_gnt = !clr_busy && b_req && (!a_req || !last_b);
  assign any_gnt = a_gnt | b_gnt;
  assign g_we = a_gnt ? a_we : b_we;
  assign rf_wr = clr_busy | (any_gnt & g_we);
  assign rf_rd = any_gnt & ~g_we;
  assign rf_addr = clr_busy ? cnt : a_gnt ? a_addr : b_gnt ? b_addr : '0;
  assign rf_din = clr_busy ? '0 : a_gnt ? a_wdata : b_gnt ? b_wdata : '0;
  assign a_rvalid = tag_v & ~tag_b;
  assign b_rvalid = tag_v & tag_b;
  assign a_rdata = a_rvalid ? rf_dout : '0;
  assign b_rdata = b_rvalid ? rf_dout : '0;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= NORMAL;
      last_b     <= 1'b1;
      cnt        <= '0;
      tag_v      <= 1'b0;
      tag_b      <= 1'b0;
      clr_done   <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err_sticky <= err_sticky | rf_error;
      tag_v      <= rf_rd;
      tag_b      <= b_gnt;
      clr_done   <= 1'b0;
      if (any_gnt) last_b <= b_gnt;
      if (state == NORMAL && clr_start) begin
        state <= CLEAR;
        cnt   <= '0;
      end else if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        if (&cnt) begin
          state    <= NORMAL;
          clr_done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed vector table plus hand-written clear/reset/error sequences.
module tb_rf_access_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, a_req, a_we, b_req, b_we, clr_start, rf_error;
  logic [2:0] a_addr, b_addr, rf_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata, rf_din, rf_dout;
  logic a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, rf_wr, rf_rd, err_sticky;
  logic [7:0] mem [8];
  int tests = 0, fails = 0;

  rf_access_ctrl #(.DW(8), .AW(3)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_din(rf_din), .rf_addr(rf_addr), .rf_wr(rf_wr), .rf_rd(rf_rd),
    .rf_dout(rf_dout), .rf_error(rf_error), .err_sticky(err_sticky)
  );

  // register file model with 1-cycle registered read
  always @(posedge clk) begin
    if (rf_wr) mem[rf_addr] <= rf_din;
    if (rf_rd) rf_dout <= mem[rf_addr];
  end

  typedef struct {
    logic ar, aw; logic [2:0] aa; logic [7:0] ad;
    logic br, bw; logic [2:0] ba; logic [7:0] bd;
    logic ag, bg, av; logic [7:0] ard; logic bv; logic [7:0] brd;
    logic wr, rd; logic [2:0] addr; logic [7:0] din;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ar, input logic aw, input logic [2:0] aa, input logic [7:0] ad,
                       input logic br, input logic bw, input logic [2:0] ba, input logic [7:0] bd,
                       input logic cs);
    @(negedge clk);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    clr_start = cs;
    #1;
    chk("mutex", {15'd0, rf_wr & rf_rd}, 16'd0);
  endtask

  initial begin
    tbl[0]  = '{1,1,3,8'h5A, 0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00, 1,0,3,8'h5A};
    tbl[1]  = '{1,0,3,8'h00, 0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00, 0,1,3,8'h00};
    tbl[2]  = '{0,0,0,8'h00, 1,1,2,8'h22, 0,1,1,8'h5A, 0,8'h00, 1,0,2,8'h22};
    tbl[3]  = '{1,0,3,8'h00, 1,0,2,8'h00, 1,0,0,8'h00, 0,8'h00, 0,1,3,8'h00};
    tbl[4]  = '{1,0,3,8'h00, 1,0,2,8'h00, 0,1,1,8'h5A, 0,8'h00, 0,1,2,8'h00};
    tbl[5]  = '{1,0,3,8'h00, 1,0,2,8'h00, 1,0,0,8'h00, 1,8'h22, 0,1,3,8'h00};
    tbl[6]  = '{1,0,3,8'h00, 1,0,2,8'h00, 0,1,1,8'h5A, 0,8'h00, 0,1,2,8'h00};
    tbl[7]  = '{1,0,3,8'h00, 1,0,2,8'h00, 1,0,0,8'h00, 1,8'h22, 0,1,3,8'h00};
    tbl[8]  = '{1,0,3,8'h00, 1,0,2,8'h00, 0,1,1,8'h5A, 0,8'h00, 0,1,2,8'h00};
    tbl[9]  = '{1,0,7,8'h00, 1,1,7,8'hC3, 1,0,0,8'h00, 1,8'h22, 0,1,7,8'h00};
    tbl[10] = '{0,0,0,8'h00, 1,1,7,8'hC3, 0,1,1,8'h00, 0,8'h00, 1,0,7,8'hC3};
    tbl[11] = '{1,0,7,8'h00, 0,0,0,8'h00, 1,0,0,8'h00, 0,8'h00, 0,1,7,8'h00};
    tbl[12] = '{0,0,0,8'h00, 0,0,0,8'h00, 0,0,1,8'hC3, 0,8'h00, 0,0,0,8'h00};
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    rf_dout = 8'h00; rf_error = 1'b0; resetn = 1'b0;
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0; clr_start = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, clr_busy, clr_done, rf_wr, rf_rd, err_sticky}, 16'd0);
    chk("rst_data", {a_rdata, b_rdata}, 16'd0);
    resetn = 1'b1;

    // basic write/read, alternating contention, write-read collision
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].ar, tbl[i].aw, tbl[i].aa, tbl[i].ad, tbl[i].br, tbl[i].bw, tbl[i].ba, tbl[i].bd, 0);
      chk($sformatf("v%0d_gnt", i), {a_gnt, b_gnt}, {tbl[i].ag, tbl[i].bg});
      chk($sformatf("v%0d_a_ret", i), {a_rvalid, a_rdata}, {tbl[i].av, tbl[i].ard});
      chk($sformatf("v%0d_b_ret", i), {b_rvalid, b_rdata}, {tbl[i].bv, tbl[i].brd});
      chk($sformatf("v%0d_op", i), {rf_wr, rf_rd, clr_busy}, {tbl[i].wr, tbl[i].rd, 1'b0});
      chk($sformatf("v%0d_addr_din", i), {rf_addr, rf_din}, {tbl[i].addr, tbl[i].din});
    end

    // fill with 0xFF, then clear with a read pending and A holding a request
    for (int i = 0; i < 8; i++) begin
      drive(1, 1, 3'(i), 8'hFF, 0, 0, 0, 0, 0);
      chk("fill_gnt", {a_gnt, rf_wr}, 2'b11);
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("clr_start_gnt", {a_gnt, rf_rd, clr_busy}, 3'b110);
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
      chk($sformatf("clr%0d_ctl", k), {clr_busy, clr_done, a_gnt, b_gnt, rf_wr, rf_rd}, 6'b100010);
      chk($sformatf("clr%0d_addr_din", k), {rf_addr, rf_din}, {3'(k), 8'h00});
      chk($sformatf("clr%0d_a_ret", k), {a_rvalid, a_rdata}, k == 0 ? {1'b1, 8'hFF} : 9'd0);
    end
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    chk("clr_done", {clr_busy, clr_done, a_gnt}, 3'b011);
    for (int i = 0; i <= 8; i++) begin
      drive(i < 8, 0, 3'(i), 0, 0, 0, 0, 0, 0);
      chk("post_clr_done", {15'd0, clr_done}, 16'd0);
      chk("post_clr_read", {a_rvalid, a_rdata}, {1'b1, 8'h00});
    end

    // clear with ignored re-pulse, aborted by reset; pointer last favoured A
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, k == 4);
      chk($sformatf("abort%0d", k), {clr_busy, a_gnt, rf_addr}, {1'b1, 1'b0, 3'(k)});
      if (k == 6) resetn = 1'b0;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    chk("abort_state", {clr_busy, clr_done, rf_wr}, 3'b000);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("abort_no_done", {clr_busy, clr_done}, 2'b00);
    drive(1, 0, 1, 0, 1, 0, 2, 0, 0);
    chk("rst_rr_a_wins", {a_gnt, b_gnt}, 2'b10);
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    chk("rst_drops_tag", {a_rvalid, b_rvalid}, 2'b00);

    // sticky error
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rf_error = 1'b1;
    chk("err_before", {15'd0, err_sticky}, 16'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rf_error = 1'b0;
    chk("err_set", {15'd0, err_sticky}, 16'd1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 1, 1, 8'h11, 0);
      chk("err_hold", {15'd0, err_sticky}, 16'd1);
    end
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b1;
    chk("err_cleared", {15'd0, err_sticky}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
